grant_burst_controller: RTL and testbench

GRANT_BURST_CONTROLLER -- requirements
Module: grant_burst_controller

---
 rtl/grant_burst_controller_if.sv | 36 +++
 rtl/grant_burst_controller.sv | 127 ++++++++++++
 tb/tb_grant_burst_controller.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/grant_burst_controller_if.sv
// Bus bundle between the upstream arbiter / requesters, the burst controller and the
// downstream resource.
//   GNT        : one-hot grant from the fixed-priority arbiter
//   req_len    : packed per-requester burst length (beats - 1), 4 bits per lane
//   req_data   : packed per-requester data, DATA_W bits per lane
//   out_ready  : downstream accepts the current beat
//   out_valid/out_data/out_id/out_last : beat presented downstream
//   busy       : controller owns the resource
//   done       : one-cycle completion pulse on bit id
//   gnt_err    : one-cycle pulse on an illegal multi-hot grant seen in idle
// Modport slave is the controller side, master is the arbiter/requester/resource side.
interface grant_burst_controller_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [3:0]          GNT;
  logic [15:0]         req_len;
  logic [4*DATA_W-1:0] req_data;
  logic                out_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_id;
  logic                out_last;
  logic                busy;
  logic [3:0]          done;
  logic                gnt_err;

  modport slave (
    input  GNT, req_len, req_data, out_ready,
    output out_valid, out_data, out_id, out_last, busy, done, gnt_err
  );

  modport master (
    output GNT, req_len, req_data, out_ready,
    input  out_valid, out_data, out_id, out_last, busy, done, gnt_err
  );
endinterface

// File: rtl/grant_burst_controller.sv
// Burst controller: captures a one-hot grant in idle, streams the granted requester's
// data lane downstream for (len + 1) beats with a valid/ready handshake, then pulses done
// for that requester and returns to idle.
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : grant_burst_controller_if.slave (grant, lengths, data lanes, beat output,
//             busy, done, gnt_err)
module grant_burst_controller #(
  parameter int unsigned DATA_W = 8
) (
  input logic                     clk,
  input logic                     reset_n,
  grant_burst_controller_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [1:0]        r_id, w_id_next;
  logic [3:0]        r_len, w_len_next;
  logic [3:0]        r_cnt, w_cnt_next;
  logic              r_gnt_err, w_gnt_err_next;

  logic [1:0]        w_gnt_id;
  logic              w_gnt_onehot;
  logic              w_gnt_multi;
  logic [DATA_W-1:0] w_data_lane [4];
  logic [3:0]        w_len_lane  [4];

  logic              w_out_valid;
  logic              w_out_last;
  logic [DATA_W-1:0] w_out_data;
  logic [1:0]        w_out_id;
  logic [3:0]        w_done;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_data_lane[i] = bus.req_data[i*DATA_W +: DATA_W];
      w_len_lane[i]  = bus.req_len[i*4 +: 4];
    end
  end

  always_comb begin
    w_gnt_id     = 2'd0;
    w_gnt_onehot = 1'b1;
    unique case (bus.GNT)
      4'b0001: w_gnt_id = 2'd0;
      4'b0010: w_gnt_id = 2'd1;
      4'b0100: w_gnt_id = 2'd2;
      4'b1000: w_gnt_id = 2'd3;
      default: w_gnt_onehot = 1'b0;
    endcase
  end

  // Two or more bits set: clearing the lowest set bit leaves something behind.
  assign w_gnt_multi = (bus.GNT & (bus.GNT - 4'd1)) != 4'd0;

  always_comb begin
    w_state_next   = r_state;
    w_id_next      = r_id;
    w_len_next     = r_len;
    w_cnt_next     = r_cnt;
    w_gnt_err_next = 1'b0;
    w_out_valid    = 1'b0;
    w_out_last     = 1'b0;
    w_out_data     = '0;
    w_out_id       = 2'd0;
    w_done         = 4'd0;
    unique case (r_state)
      StIdle: begin
        if (w_gnt_onehot) begin
          w_id_next    = w_gnt_id;
          w_len_next   = w_len_lane[w_gnt_id];
          w_cnt_next   = 4'd0;
          w_state_next = StXfer;
        end else if (w_gnt_multi) begin
          w_gnt_err_next = 1'b1;
        end
      end
      StXfer: begin
        // Data is the live lane of the owner, so a stalled beat tracks its requester.
        w_out_valid = 1'b1;
        w_out_id    = r_id;
        w_out_data  = w_data_lane[r_id];
        w_out_last  = (r_cnt == r_len);
        if (bus.out_ready) begin
          if (w_out_last) begin
            w_state_next = StDone;
          end else begin
            w_cnt_next = r_cnt + 4'd1;
          end
        end
      end
      StDone: begin
        w_done       = 4'd1 << r_id;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_id      <= 2'd0;
      r_len     <= 4'd0;
      r_cnt     <= 4'd0;
      r_gnt_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_id      <= w_id_next;
      r_len     <= w_len_next;
      r_cnt     <= w_cnt_next;
      r_gnt_err <= w_gnt_err_next;
    end
  end

  assign bus.out_valid = w_out_valid;
  assign bus.out_last  = w_out_last;
  assign bus.out_data  = w_out_data;
  assign bus.out_id    = w_out_id;
  assign bus.done      = w_done;
  assign bus.busy      = (r_state == StXfer) || (r_state == StDone);
  // Registered so the pulse is a clean single cycle and reads zero straight after reset.
  assign bus.gnt_err   = r_gnt_err;

endmodule

// File: tb/tb_grant_burst_controller.sv
// Scoreboard bench for grant_burst_controller: the driver pushes the expected beats,
// done pulses and error pulses of each transaction; a negedge monitor pops and compares.
module tb_grant_burst_controller;
  localparam int unsigned DATA_W = 8;

  typedef struct {
    logic [1:0] id;
    logic       last;
  } beat_t;

  logic clk;
  logic reset_n;

  grant_burst_controller_if #(.DATA_W(DATA_W)) bus ();

  grant_burst_controller #(.DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t      beat_q[$];
  logic [3:0] done_q[$];
  int         exp_err   = 0;
  int         checks    = 0;
  int         errors    = 0;
  int         cyc       = 0;
  int         last_cyc  = -1000;
  int         last_gap  = 0;
  bit         new_burst = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] lane_data(input logic [1:0] id);
    logic [4*DATA_W-1:0] v;
    v = bus.req_data;
    return v[int'(id)*DATA_W +: DATA_W];
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    beat_t h;
    int    gap;
    cyc++;
    if (!reset_n) begin
      new_burst = 1'b1;
      last_cyc  = -1000;
    end else begin
      chk("busy", {31'd0, bus.busy}, {31'd0, bus.out_valid || (bus.done != 4'd0)});
      if (bus.out_valid) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          h = beat_q[0];
          chk("out_id", {30'd0, bus.out_id}, {30'd0, h.id});
          chk("out_last", {31'd0, bus.out_last}, {31'd0, h.last});
          chk("out_data", {24'd0, bus.out_data}, {24'd0, lane_data(h.id)});
          if (new_burst) begin
            gap       = cyc - last_cyc;
            last_gap  = gap;
            new_burst = 1'b0;
            chk("gap_min3", {31'd0, gap >= 3}, 32'd1);
          end
          if (bus.out_ready) begin
            void'(beat_q.pop_front());
            if (h.last) begin
              last_cyc  = cyc;
              new_burst = 1'b1;
            end
          end
        end
      end else begin
        chk("idle_outputs", {21'd0, bus.out_data, bus.out_id, bus.out_last}, 32'd0);
      end
      if (bus.done != 4'd0) begin
        if (done_q.size() == 0) chk("unexpected_done", {28'd0, bus.done}, 32'd0);
        else chk("done", {28'd0, bus.done}, {28'd0, done_q.pop_front()});
      end
      if (bus.gnt_err) begin
        if (exp_err == 0) begin
          chk("unexpected_gnt_err", 32'd1, 32'd0);
        end else begin
          exp_err--;
          chk("gnt_err", 32'd1, 32'd1);
        end
      end
    end
  end

  task automatic randomize_data();
    for (int i = 0; i < 4; i++) bus.req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
  endtask

  // Issue a grant and record the whole expected transaction.
  task automatic start_burst(input int id, input int len);
    beat_t b;
    bus.req_len = 16'($urandom);
    bus.req_len[id*4 +: 4] = 4'(len);
    bus.GNT = 4'd1 << id;
    randomize_data();
    for (int k = 0; k <= len; k++) begin
      b.id   = 2'(id);
      b.last = (k == len);
      beat_q.push_back(b);
    end
    done_q.push_back(4'd1 << id);
  endtask

  // Run until the done pulse; returns at posedge+1 of the done cycle.
  task automatic wait_done(input bit rand_ready, input logic [3:0] gnt_mid);
    bit ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? 1'($urandom) : 1'b1;
      randomize_data();
      if (bus.out_valid) bus.GNT = gnt_mid;
      if (bus.done != 4'd0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {17'd0, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.gnt_err,
               bus.out_id, bus.out_data}, 32'd0);
  endtask

  initial begin
    logic [3:0] m;
    reset_n       = 1'b0;
    bus.GNT       = 4'd0;
    bus.req_len   = 16'd0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_state");
    tick();
    reset_n = 1'b1;
    tick();

    // Three beats on id 2, then busy drops.
    start_burst(2, 2);
    wait_done(1'b0, 4'd0);
    bus.GNT = 4'd0;
    tick();
    chk("busy_after_done", {31'd0, bus.busy}, 32'd0);

    // Single beat on id 3 with a stalling downstream.
    start_burst(3, 0);
    wait_done(1'b1, 4'd0);
    bus.GNT = 4'd0;
    repeat (2) tick();

    // Illegal multi-hot grant in idle.
    bus.GNT = 4'b0011;
    exp_err++;
    tick();
    bus.GNT = 4'd0;
    repeat (2) begin
      tick();
      chk("busy_after_gnt_err", {31'd0, bus.busy}, 32'd0);
    end

    // Sixteen beats on id 1 while the grant moves to id 3.
    start_burst(1, 15);
    wait_done(1'b0, 4'b1000);
    bus.GNT = 4'd0;
    repeat (2) tick();

    // Reset on the second beat of a four-beat burst.
    start_burst(2, 3);
    bus.out_ready = 1'b1;
    tick();
    bus.GNT = 4'd0;
    tick();
    reset_n = 1'b0;
    beat_q.delete();
    done_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("mid_burst_reset");
    tick();
    reset_n = 1'b1;
    start_burst(0, 2);
    wait_done(1'b0, 4'd0);
    bus.GNT = 4'd0;
    repeat (2) tick();

    // Back-to-back grants: the second grant is already up while done pulses.
    start_burst(1, 1);
    wait_done(1'b0, 4'd0);
    start_burst(0, 1);
    wait_done(1'b0, 4'd0);
    chk("b2b_gap", last_gap, 32'd3);
    bus.GNT = 4'd0;
    tick();

    // Randomized bursts with noisy mid-burst grants, stalls and idle-time errors.
    for (int n = 0; n < 25; n++) begin
      start_burst(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      wait_done(1'($urandom), 4'($urandom));
      bus.GNT = 4'd0;
      if ($urandom_range(0, 2) == 0) begin
        do m = 4'($urandom); while ($countones(m) < 2);
        bus.GNT = m;
        exp_err++;
        tick();
        tick();
        bus.GNT = 4'd0;
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (5) tick();
    chk("beats_left", beat_q.size(), 32'd0);
    chk("dones_left", done_q.size(), 32'd0);
    chk("errs_left", exp_err, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
